// File: rtl/instruction_queue_pkg.sv
// RV32I front-end types shared by the fetch queue, its decoder and the ROB:
// opcode encoding and the decoded per-instruction bundle.
package rv32i_types;

    typedef enum logic [6:0] {
        op_lui   = 7'b0110111,
        op_auipc = 7'b0010111,
        op_jal   = 7'b1101111,
        op_jalr  = 7'b1100111,
        op_br    = 7'b1100011,
        op_load  = 7'b0000011,
        op_store = 7'b0100011,
        op_imm   = 7'b0010011,
        op_reg   = 7'b0110011,
        op_csr   = 7'b1110011
    } rv32i_opcode;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] next_pc;
        logic [31:0] instruction;
        rv32i_opcode opcode;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] i_imm;
        logic [31:0] s_imm;
        logic [31:0] b_imm;
        logic [31:0] u_imm;
        logic [31:0] j_imm;
    } pci_t;

endpackage

// File: rtl/instruction_queue_instr_decoder.sv
// Purely combinational RV32I field extraction: raw word + fetch PC -> pci_t.
// Opcodes outside rv32i_opcode pass through unchanged for the ROB to reject.
module instr_decoder
    import rv32i_types::*;
(
    input  logic [31:0] instr,
    input  logic [31:0] pc,
    output pci_t        pci
);

    // NOTE: every field gets a default before any conditional logic so no
    // path through the block can leave an output unassigned and infer a latch.
    always_comb begin
        pci             = '0;
        pci.pc          = pc;
        pci.next_pc     = pc + 32'd4;
        pci.instruction = instr;
        pci.opcode      = rv32i_opcode'(instr[6:0]);
        pci.rd          = instr[11:7];
        pci.funct3      = instr[14:12];
        pci.rs1         = instr[19:15];
        pci.rs2         = instr[24:20];
        pci.funct7      = instr[31:25];
        pci.i_imm       = {{21{instr[31]}}, instr[30:20]};
        pci.s_imm       = {{21{instr[31]}}, instr[30:25], instr[11:7]};
        pci.b_imm       = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
        pci.u_imm       = {instr[31:12], 12'h000};
        pci.j_imm       = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
    end

endmodule

// File: rtl/instruction_queue.sv
// Fetch unit plus circular instruction FIFO in front of the ROB. Buffered
// entries keep the raw word and PC; decode happens once on the head/bypass mux.
module instruction_queue
    import rv32i_types::*;
#(
    parameter int          size     = 8,
    parameter int          width    = 32,
    parameter logic [31:0] reset_pc = 32'h00000060
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             instr_mem_resp,
    input  logic [width-1:0] instr_mem_rdata,
    input  logic             dequeue,
    input  logic             flush,
    input  logic [width-1:0] flush_pc,
    output logic             instr_mem_read,
    output logic [width-1:0] instr_mem_address,
    output pci_t             pci,
    output logic             empty,
    output logic             full
);

    localparam int               idx_w    = $clog2(size);
    localparam int               cnt_w    = idx_w + 1;
    localparam logic [cnt_w-1:0] full_cnt = cnt_w'(size);

    typedef enum logic [1:0] {
        FETCH,
        STALL,
        DROP
    } fetch_state_e;

    typedef struct packed {
        logic [width-1:0] word;
        logic [width-1:0] pc;
    } entry_t;

    fetch_state_e     state_q, state_d;
    logic [width-1:0] pc_q, pc_d;
    logic [width-1:0] drop_addr_q, drop_addr_d;
    logic [idx_w-1:0] front_q, front_d;
    logic [idx_w-1:0] rear_q, rear_d;
    logic [cnt_w-1:0] count_q, count_d;
    entry_t           arr_q [size];
    entry_t           arr_d [size];

    logic             read_now;
    logic             fetch_hit;
    logic             enq;
    logic             deq;
    logic [width-1:0] dec_word;
    logic [width-1:0] dec_pc;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        drop_addr_d = drop_addr_q;
        front_d     = front_q;
        rear_d      = rear_q;
        count_d     = count_q;
        arr_d       = arr_q;
        enq         = 1'b0;
        deq         = 1'b0;

        unique case (state_q)
            FETCH:   read_now = (count_q != full_cnt);
            DROP:    read_now = 1'b1;
            default: read_now = 1'b0;
        endcase
        fetch_hit = (state_q == FETCH) && read_now && instr_mem_resp;

        if (flush) begin
            pc_d    = flush_pc;
            front_d = '0;
            rear_d  = '0;
            count_d = '0;
            // An outstanding read must still be drained at its original address.
            if (state_q == DROP) begin
                state_d = instr_mem_resp ? FETCH : DROP;
            end else if (read_now && !instr_mem_resp) begin
                state_d     = DROP;
                drop_addr_d = pc_q;
            end else begin
                state_d = FETCH;
            end
        end else begin
            deq = dequeue && (count_q != '0);
            // A response consumed through the bypass never touches the array.
            enq = fetch_hit && !((count_q == '0) && dequeue);
            if (enq) begin
                arr_d[rear_q] = '{word: instr_mem_rdata, pc: pc_q};
                rear_d        = rear_q + 1'b1;
            end
            if (deq) begin
                front_d = front_q + 1'b1;
            end
            count_d = count_q + cnt_w'(enq) - cnt_w'(deq);

            unique case (state_q)
                FETCH: begin
                    if (fetch_hit) begin
                        pc_d = pc_q + width'(4);
                        if (count_d == full_cnt) state_d = STALL;
                    end
                end
                STALL:   if (count_q != full_cnt) state_d = FETCH;
                DROP:    if (instr_mem_resp) state_d = FETCH;
                default: state_d = FETCH;
            endcase
        end
    end

    // NOTE: the entry array is cleared on reset too, so a freshly reset queue
    // never exposes stale words on the head mux.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= FETCH;
            pc_q        <= reset_pc;
            drop_addr_q <= '0;
            front_q     <= '0;
            rear_q      <= '0;
            count_q     <= '0;
            for (int i = 0; i < size; i++) begin
                arr_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            drop_addr_q <= drop_addr_d;
            front_q     <= front_d;
            rear_q      <= rear_d;
            count_q     <= count_d;
            arr_q       <= arr_d;
        end
    end

    assign instr_mem_read    = !rst && read_now;
    assign instr_mem_address = (state_q == DROP) ? drop_addr_q : pc_q;
    assign empty             = rst || (count_q == '0);
    assign full              = !rst && (count_q == full_cnt);

    // Empty queue: the arriving memory word is presented directly on pci.
    always_comb begin
        if (rst) begin
            dec_word = '0;
            dec_pc   = '0;
        end else if (count_q == '0) begin
            dec_word = instr_mem_rdata;
            dec_pc   = pc_q;
        end else begin
            dec_word = arr_q[front_q].word;
            dec_pc   = arr_q[front_q].pc;
        end
    end

    instr_decoder u_decoder (
        .instr (dec_word),
        .pc    (dec_pc),
        .pci   (pci)
    );

endmodule

// File: tb/tb_instruction_queue.sv
// Lockstep bench: a queue-based reference model predicts every output each
// cycle under directed scenarios followed by randomized traffic.
module tb_instruction_queue;
    import rv32i_types::*;

    localparam int          SIZE     = 8;
    localparam logic [31:0] RESET_PC = 32'h00000060;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_mem_resp;
    logic [31:0] instr_mem_rdata;
    logic        dequeue;
    logic        flush;
    logic [31:0] flush_pc;
    logic        instr_mem_read;
    logic [31:0] instr_mem_address;
    pci_t        pci;
    logic        empty;
    logic        full;

    always #5 clk = ~clk;

    instruction_queue #(.size(SIZE), .width(32), .reset_pc(RESET_PC)) dut (
        .clk               (clk),
        .rst               (rst),
        .instr_mem_resp    (instr_mem_resp),
        .instr_mem_rdata   (instr_mem_rdata),
        .dequeue           (dequeue),
        .flush             (flush),
        .flush_pc          (flush_pc),
        .instr_mem_read    (instr_mem_read),
        .instr_mem_address (instr_mem_address),
        .pci               (pci),
        .empty             (empty),
        .full              (full)
    );

    typedef struct {
        logic [31:0] w;
        logic [31:0] pc;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_pc;
    logic [31:0] m_drop_addr;
    bit          m_stalled;
    bit          m_dropping;
    bit          exp_read;
    int          n_vec = 0;
    int          n_mis = 0;
    int          age   = 0;
    int          lat   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] imm_i(input logic [31:0] w);
        return 32'($signed(w) >>> 20);
    endfunction

    function automatic logic [31:0] imm_b(input logic [31:0] w);
        logic [31:0] r;
        r = (((w >> 7) & 32'h1) << 11) | (((w >> 25) & 32'h3F) << 5) | (((w >> 8) & 32'hF) << 1);
        if (w[31]) r = r | 32'hFFFFF000;
        return r;
    endfunction

    function automatic logic [31:0] imm_j(input logic [31:0] w);
        logic [31:0] r;
        r = (((w >> 12) & 32'hFF) << 12) | (((w >> 20) & 32'h1) << 11) | (((w >> 21) & 32'h3FF) << 1);
        if (w[31]) r = r | 32'hFFF00000;
        return r;
    endfunction

    function automatic bit model_read();
        return !rst && (m_dropping || (!m_stalled && mq.size() < SIZE));
    endfunction

    task automatic compare();
        logic [31:0] hw;
        logic [31:0] hp;
        exp_read = model_read();
        check("read", instr_mem_read, exp_read);
        if (exp_read) check("address", instr_mem_address, m_dropping ? m_drop_addr : m_pc);
        check("empty", empty, rst || mq.size() == 0);
        check("full", full, !rst && mq.size() == SIZE);
        if (rst) begin
            hw = '0;
            hp = '0;
        end else if (mq.size() > 0) begin
            hw = mq[0].w;
            hp = mq[0].pc;
        end else begin
            hw = instr_mem_rdata;
            hp = m_pc;
        end
        if (rst || mq.size() > 0 || instr_mem_resp) begin
            check("pci_pc", pci.pc, hp);
            check("pci_next_pc", pci.next_pc, hp + 32'd4);
            check("pci_instr", pci.instruction, hw);
            check("pci_opcode", pci.opcode, hw & 32'h7F);
            check("pci_rd", pci.rd, (hw >> 7) & 32'h1F);
            check("pci_rs1", pci.rs1, (hw >> 15) & 32'h1F);
            check("pci_i_imm", pci.i_imm, imm_i(hw));
            check("pci_b_imm", pci.b_imm, imm_b(hw));
            check("pci_u_imm", pci.u_imm, hw & 32'hFFFFF000);
            check("pci_j_imm", pci.j_imm, imm_j(hw));
        end
    endtask

    task automatic drive(input bit r, input bit rsp, input logic [31:0] wd,
                         input bit dq, input bit fl, input logic [31:0] fpc);
        @(negedge clk);
        rst             = r;
        instr_mem_resp  = rsp;
        instr_mem_rdata = wd;
        dequeue         = dq;
        flush           = fl;
        flush_pc        = fpc;
        #1;
        compare();
    endtask

    task automatic advance();
        int n0;
        bit got;
        @(posedge clk);
        got = instr_mem_resp && exp_read;
        n0  = mq.size();
        if (rst) begin
            mq.delete();
            m_pc        = RESET_PC;
            m_stalled   = 1'b0;
            m_dropping  = 1'b0;
            m_drop_addr = '0;
        end else if (flush) begin
            if (m_dropping) begin
                m_dropping = !got;
            end else if (exp_read && !got) begin
                m_dropping  = 1'b1;
                m_drop_addr = m_pc;
            end else begin
                m_dropping = 1'b0;
            end
            m_stalled = 1'b0;
            mq.delete();
            m_pc = flush_pc;
        end else begin
            if (dequeue && n0 > 0) void'(mq.pop_front());
            if (m_dropping) begin
                if (got) m_dropping = 1'b0;
            end else if (m_stalled) begin
                if (n0 < SIZE) m_stalled = 1'b0;
            end else if (got) begin
                if (!(n0 == 0 && dequeue)) mq.push_back('{w: instr_mem_rdata, pc: m_pc});
                m_pc = m_pc + 32'd4;
                if (mq.size() == SIZE) m_stalled = 1'b1;
            end
        end
    endtask

    task automatic step(input bit r, input bit rsp, input logic [31:0] wd,
                        input bit dq, input bit fl, input logic [31:0] fpc);
        drive(r, rsp, wd, dq, fl, fpc);
        advance();
    endtask

    task automatic do_reset();
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
    endtask

    task automatic random_cycles(input int n, input int lat_min, input int lat_max,
                                 input int p_deq, input int p_flush, input int p_rst);
        bit          rd, rsp, dq, fl, r;
        logic [31:0] fpc;
        age = 0;
        lat = $urandom_range(lat_max, lat_min);
        for (int i = 0; i < n; i++) begin
            r   = ($urandom_range(999, 0) < p_rst);
            rd  = model_read();
            rsp = !r && rd && (age >= lat);
            if (mq.size() > 0) dq = ($urandom_range(99, 0) < p_deq);
            else               dq = rsp && ($urandom_range(99, 0) < p_deq);
            fl  = ($urandom_range(99, 0) < p_flush);
            fpc = ($urandom_range(3, 0) == 0) ? 32'hFFFFFFF0 : ($urandom & 32'hFFFFFFFC);
            step(r, rsp, $urandom, dq, fl, fpc);
            if (r || rsp || !rd) begin
                age = 0;
                lat = $urandom_range(lat_max, lat_min);
            end else begin
                age++;
            end
        end
    endtask

    initial begin
        rst = 1'b1; instr_mem_resp = 1'b0; instr_mem_rdata = '0;
        dequeue = 1'b0; flush = 1'b0; flush_pc = '0;

        // Fill to full with one-cycle memory latency, then release one slot.
        do_reset();
        random_cycles(20, 1, 1, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        check("fill_full", full, 1);
        check("fill_stall_read", instr_mem_read, 0);
        advance();
        step(0, 0, 0, 1, 0, 0);
        random_cycles(8, 1, 1, 0, 0, 0);

        // Bypass into an empty queue.
        do_reset();
        drive(0, 1, 32'h00A00093, 1, 0, 0);
        check("byp_opcode", pci.opcode, 32'h13);
        check("byp_rd", pci.rd, 1);
        check("byp_pc", pci.pc, 32'h60);
        advance();
        drive(0, 0, 0, 0, 0, 0);
        check("byp_empty", empty, 1);
        check("byp_next_addr", instr_mem_address, 32'h64);
        advance();

        // Simultaneous enqueue/dequeue at size-1, wrapping both indices.
        do_reset();
        for (int i = 0; i < 7; i++) step(0, 1, $urandom, 0, 0, 0);
        step(0, 1, $urandom, 1, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        check("wrap_not_full", full, 0);
        advance();
        for (int i = 0; i < 8; i++) step(0, 0, 0, 1, 0, 0);

        // Flush while a read of 0x68 is outstanding.
        do_reset();
        step(0, 1, $urandom, 1, 0, 0);
        step(0, 1, $urandom, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 32'h200);
        drive(0, 0, 0, 0, 0, 0);
        check("drop_hold_addr", instr_mem_address, 32'h68);
        advance();
        step(0, 0, 0, 0, 0, 0);
        step(0, 1, $urandom, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        check("drop_new_addr", instr_mem_address, 32'h200);
        check("drop_empty", empty, 1);
        advance();

        // Flush coinciding with a response, four entries buffered.
        do_reset();
        for (int i = 0; i < 4; i++) step(0, 1, $urandom, 0, 0, 0);
        step(0, 1, $urandom, 0, 1, 32'h300);
        drive(0, 0, 0, 0, 0, 0);
        check("flush_resp_empty", empty, 1);
        check("flush_resp_addr", instr_mem_address, 32'h300);
        advance();

        // Reset mid-stream with five entries buffered.
        do_reset();
        for (int i = 0; i < 5; i++) step(0, 1, $urandom, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0);
        check("rst_empty", empty, 1);
        check("rst_read", instr_mem_read, 0);
        advance();
        drive(0, 0, 0, 0, 0, 0);
        check("rst_restart_addr", instr_mem_address, 32'h60);
        advance();

        // Randomized traffic.
        random_cycles(3000, 0, 3, 40, 3, 4);
        random_cycles(2000, 0, 1, 85, 1, 2);
        random_cycles(2000, 0, 2, 10, 2, 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
